param_updown_counter: RTL and testbench
=======================================

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 The block SHALL have parameter MODULUS, default 16: count sequence length, legal range 2..2**WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 wraps at the ends, 1 holds at the ends.
REQ-004 The block SHALL have port clock, input, 1: single clock; all state changes on its negative edge.
REQ-005 The block SHALL have port clear, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port count_enable, input, 1: 1 = advance one step per clock.
REQ-007 The block SHALL have port up_down, input, 1: 1 = count up, 0 = count down.
REQ-008 The block SHALL have port load, input, 1: synchronous parallel load request.
REQ-009 The block SHALL have port load_value, input, WIDTH: value to load.
REQ-010 The block SHALL have port Q, output, WIDTH: current count.
REQ-011 The block SHALL have port Qbar, output, WIDTH: bitwise complement of Q at all times.
REQ-012 The block SHALL have port terminal_count, output, 1: combinational end-of-sequence indicator.
REQ-013 The block SHALL have port wrapped, output, 1: sticky flag, set when a wrap occurs.

Function
REQ-014 State SHALL update only on the negedge of clock, except during the asynchronous clear.
REQ-015 Priority at each edge SHALL be: load, then count_enable, then hold.
REQ-016 Load SHALL set Q = load_value, or MODULUS-1 if load_value >= MODULUS, and SHALL clear wrapped, regardless of count_enable.
REQ-017 Count up SHALL advance Q by 1 if Q < MODULUS-1.
REQ-018 Count up at Q = MODULUS-1 SHALL, with SATURATE=0, go to Q = 0 and set wrapped; with SATURATE=1, hold Q with wrapped unchanged.
REQ-019 Count down SHALL decrement Q by 1 if Q > 0.
REQ-020 Count down at Q = 0 SHALL, with SATURATE=0, go to Q = MODULUS-1 and set wrapped; with SATURATE=1, hold Q.
REQ-021 A change of up_down between edges SHALL take effect on the next edge with no extra latency or lost count.
REQ-022 terminal_count SHALL be 1 iff count_enable=1, load=0, and either (up_down=1 and Q=MODULUS-1) or (up_down=0 and Q=0).
REQ-023 Q SHALL never hold a value >= MODULUS after any reset, load, or count.
REQ-024 With count_enable=0 and load=0, Q and wrapped SHALL hold.

Reset
REQ-025 clear=0 SHALL immediately force Q=0, Qbar=all ones, and wrapped=0, independent of clock.
REQ-026 While clear=0, all edges SHALL be ignored, including load.
REQ-027 After clear rises, the first negedge SHALL act normally with no dead cycle.
REQ-028 terminal_count SHALL follow REQ-022 during reset, so it is 1 if count_enable=1, up_down=0, and load=0.

Structure
REQ-029 There SHALL be no shared package; the UP=1/DOWN=0 encodings SHALL be local parameters.
REQ-030 Next-count computation (wrap/saturate/clamp) SHALL be one combinational sub-module, updown_next, instantiated once.
REQ-031 The state register and wrapped flag SHALL reside in the top module.
REQ-032 Qbar SHALL be a continuous assignment.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-033 Pulse clear=0, then enable up-counting for 12 edges -> Q = 1..9, 0, 1, 2; terminal_count=1 at Q=9; wrapped=1 from the 0 onward.
REQ-034 Load 3, then count down for 5 edges -> Q = 2, 1, 0, 9, 8; wrapped set at 9.
REQ-035 With SATURATE=1, load 8, then count up for 3 edges -> Q = 9, 9, 9; wrapped=0; terminal_count=1 while at 9.
REQ-036 Load 14 -> Q=9; assert load and count_enable together with load_value=5 -> Q=5, and wrapped clears.
REQ-037 Drop clear mid-count between edges at Q=6 -> Q=0 and Qbar=4'b1111 at once; the next edges are ignored until clear=1.
REQ-038 Toggle up_down every edge starting from Q=4 -> Q = 5, 4, 5, 4; Qbar always equals ~Q.

Source files
------------

// File: rtl/updown_next.sv
// Combinational next-count logic for param_updown_counter: load clamping,
// up/down stepping, and the wrap or saturate behaviour at the sequence ends.
module updown_next #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic [WIDTH-1:0] count,
    input  logic             count_enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_event,
    output logic             terminal_count
);

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic             at_end;
    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        at_end = 1'b0;
        unique case (up_down)
            UP:      at_end = (count == MAX_COUNT);
            DOWN:    at_end = (count == '0);
            default: at_end = 1'b0;
        endcase
    end

    // Compare at 64 bits so MODULUS = 2**WIDTH never truncates.
    assign load_clamped = (64'(load_value) >= MODULUS) ? MAX_COUNT : load_value;

    always_comb begin
        next_count = count;
        wrap_event = 1'b0;
        if (load) begin
            next_count = load_clamped;
        end else if (count_enable) begin
            if (at_end) begin
                if (!SATURATE) begin
                    next_count = (up_down == UP) ? '0 : MAX_COUNT;
                    wrap_event = 1'b1;
                end
            end else begin
                next_count = (up_down == UP) ? count + 1'b1 : count - 1'b1;
            end
        end
    end

    assign terminal_count = count_enable & ~load & at_end;

endmodule

// File: rtl/param_updown_counter.sv
// Parameterised modulo up/down counter, negedge clocked, with parallel load,
// optional saturation and a sticky wrap flag.
module param_updown_counter #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             count_enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             terminal_count,
    output logic             wrapped
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic             wrap_event;

    updown_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .SATURATE(SATURATE)
    ) u_next (
        .count         (count_q),
        .count_enable  (count_enable),
        .up_down       (up_down),
        .load          (load),
        .load_value    (load_value),
        .next_count    (count_d),
        .wrap_event    (wrap_event),
        .terminal_count(terminal_count)
    );

    // A load restarts the sequence, so it also forgets any earlier wrap.
    assign wrapped_d = load ? 1'b0 : (wrapped_q | wrap_event);

    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign Q       = count_q;
    assign Qbar    = ~count_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter: a wrapping and a saturating instance
// (WIDTH=4, MODULUS=10) driven together and compared with an arithmetic model.
module tb_param_updown_counter;

    localparam int MOD = 10;

    logic       clock = 1'b1;
    logic       clear;
    logic       en, ud, ld;
    logic [3:0] lv;
    logic [3:0] dq[2];
    logic [3:0] dqb[2];
    logic       dtc[2];
    logic       dw[2];

    int m_q[2];
    int m_w[2];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_wrap (
        .clock(clock), .clear(clear), .count_enable(en), .up_down(ud), .load(ld),
        .load_value(lv), .Q(dq[0]), .Qbar(dqb[0]), .terminal_count(dtc[0]), .wrapped(dw[0])
    );

    param_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_sat (
        .clock(clock), .clear(clear), .count_enable(en), .up_down(ud), .load(ld),
        .load_value(lv), .Q(dq[1]), .Qbar(dqb[1]), .terminal_count(dtc[1]), .wrapped(dw[1])
    );

    // Reference: k=0 wraps modulo MOD, k=1 sticks at the ends.
    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            if (ld) begin
                m_q[k] = (int'(lv) >= MOD) ? MOD - 1 : int'(lv);
                m_w[k] = 0;
            end else if (en) begin
                if (ud) begin
                    if (m_q[k] == MOD - 1) begin
                        if (k == 0) begin m_q[k] = 0; m_w[k] = 1; end
                    end else m_q[k] = m_q[k] + 1;
                end else begin
                    if (m_q[k] == 0) begin
                        if (k == 0) begin m_q[k] = MOD - 1; m_w[k] = 1; end
                    end else m_q[k] = m_q[k] - 1;
                end
            end
        end
    endfunction

    function automatic bit model_tc(int k);
        return en && !ld && (ud ? (m_q[k] == MOD - 1) : (m_q[k] == 0));
    endfunction

    task automatic step();
        @(negedge clock);
        if (clear) model_edge();
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0; en = 1'b1; ud = 1'b0; ld = 1'b0; lv = 4'd0;
        m_q = '{0, 0}; m_w = '{0, 0};
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (dq[k] !== 4'd0 || dqb[k] !== 4'hf || dw[k] !== 1'b0 || dtc[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset[%0d]: Q=%h Qbar=%h w=%b tc=%b expected 0 f 0 1",
                         k, dq[k], dqb[k], dw[k], dtc[k]);
            end
        end
        ld = 1'b1; lv = 4'd7;
        step(); step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (dq[k] !== 4'd0) begin
                n_fail++; $display("FAIL reset_ignores_load[%0d]: Q=%h expected 0", k, dq[k]);
            end
        end
        #3; clear = 1'b1; ld = 1'b0; en = 1'b0;
        step();
        n_checks++;
        if (dq[0] !== 4'd0 || dw[0] !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: Q=%h w=%b expected 0 0", dq[0], dw[0]);
        end
    endtask

    task automatic test_count_up();
        int exp_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int prev = 0;
        en = 1'b1; ud = 1'b1; ld = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (dtc[0] !== (prev == 9)) begin
                n_fail++; $display("FAIL up_tc step %0d: tc=%b expected %b", i, dtc[0], prev == 9);
            end
            step();
            n_checks++;
            if (dq[0] !== 4'(exp_q[i]) || dqb[0] !== ~4'(exp_q[i]) || dw[0] !== (i >= 9)) begin
                n_fail++;
                $display("FAIL up_count step %0d: Q=%h Qbar=%h w=%b expected Q=%h w=%b",
                         i, dq[0], dqb[0], dw[0], exp_q[i], i >= 9);
            end
            n_checks++;
            if (dq[1] !== 4'(m_q[1]) || dw[1] !== m_w[1][0]) begin
                n_fail++; $display("FAIL up_sat step %0d: Q=%h w=%b expected %h %b",
                                   i, dq[1], dw[1], m_q[1], m_w[1][0]);
            end
            prev = exp_q[i];
        end
    endtask

    task automatic test_load_down();
        int exp_q[5] = '{2, 1, 0, 9, 8};
        ld = 1'b1; lv = 4'd3; en = 1'b0;
        step();
        n_checks++;
        if (dq[0] !== 4'd3 || dw[0] !== 1'b0) begin
            n_fail++; $display("FAIL load3: Q=%h w=%b expected 3 0", dq[0], dw[0]);
        end
        ld = 1'b0; en = 1'b1; ud = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (dq[0] !== 4'(exp_q[i]) || dw[0] !== (i >= 3)) begin
                n_fail++; $display("FAIL down step %0d: Q=%h w=%b expected %h %b",
                                   i, dq[0], dw[0], exp_q[i], i >= 3);
            end
            n_checks++;
            if (dq[1] !== 4'(m_q[1])) begin
                n_fail++; $display("FAIL down_sat step %0d: Q=%h expected %h", i, dq[1], m_q[1]);
            end
        end
    endtask

    task automatic test_saturate();
        ld = 1'b1; lv = 4'd8; en = 1'b0;
        step();
        ld = 1'b0; en = 1'b1; ud = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dtc[1] !== (i != 0)) begin
                n_fail++; $display("FAIL sat_tc step %0d: tc=%b expected %b", i, dtc[1], i != 0);
            end
            step();
            n_checks++;
            if (dq[1] !== 4'd9 || dw[1] !== 1'b0) begin
                n_fail++; $display("FAIL sat step %0d: Q=%h w=%b expected 9 0", i, dq[1], dw[1]);
            end
        end
        n_checks++;
        if (dtc[1] !== 1'b1) begin
            n_fail++; $display("FAIL sat_tc_hold: tc=%b expected 1", dtc[1]);
        end
    endtask

    task automatic test_load_clamp();
        ld = 1'b1; lv = 4'd14; en = 1'b0;
        step();
        n_checks++;
        if (dq[0] !== 4'd9 || dq[1] !== 4'd9) begin
            n_fail++; $display("FAIL clamp: Q=%h/%h expected 9/9", dq[0], dq[1]);
        end
        ld = 1'b0; en = 1'b1; ud = 1'b1;
        step();
        n_checks++;
        if (dq[0] !== 4'd0 || dw[0] !== 1'b1) begin
            n_fail++; $display("FAIL clamp_wrap: Q=%h w=%b expected 0 1", dq[0], dw[0]);
        end
        ld = 1'b1; lv = 4'd5;
        #1;
        n_checks++;
        if (dtc[0] !== 1'b0) begin
            n_fail++; $display("FAIL load_masks_tc: tc=%b expected 0", dtc[0]);
        end
        step();
        n_checks++;
        if (dq[0] !== 4'd5 || dw[0] !== 1'b0) begin
            n_fail++; $display("FAIL load_over_enable: Q=%h w=%b expected 5 0", dq[0], dw[0]);
        end
    endtask

    task automatic test_async_clear();
        ld = 1'b1; lv = 4'd4; en = 1'b0;
        step();
        ld = 1'b0; en = 1'b1; ud = 1'b1;
        step(); step();
        n_checks++;
        if (dq[0] !== 4'd6) begin
            n_fail++; $display("FAIL pre_clear: Q=%h expected 6", dq[0]);
        end
        #3; clear = 1'b0; m_q = '{0, 0}; m_w = '{0, 0};
        #1;
        n_checks++;
        if (dq[0] !== 4'd0 || dqb[0] !== 4'hf || dw[0] !== 1'b0) begin
            n_fail++; $display("FAIL async_clear: Q=%h Qbar=%h w=%b expected 0 f 0",
                               dq[0], dqb[0], dw[0]);
        end
        ld = 1'b1; lv = 4'd7;
        step(); step();
        n_checks++;
        if (dq[0] !== 4'd0) begin
            n_fail++; $display("FAIL clear_ignores_edges: Q=%h expected 0", dq[0]);
        end
        #3; clear = 1'b1; ld = 1'b0; en = 1'b1; ud = 1'b1;
        step();
        n_checks++;
        if (dq[0] !== 4'd1) begin
            n_fail++; $display("FAIL first_edge_after_clear: Q=%h expected 1", dq[0]);
        end
    endtask

    task automatic test_toggle();
        ld = 1'b1; lv = 4'd4; en = 1'b0;
        step();
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ud = (i % 2 == 0);
            step();
            n_checks++;
            if (dq[0] !== (ud ? 4'd5 : 4'd4) || dqb[0] !== ~dq[0]) begin
                n_fail++; $display("FAIL toggle step %0d: Q=%h Qbar=%h expected Q=%h",
                                   i, dq[0], dqb[0], ud ? 4'd5 : 4'd4);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 3) != 0);
            ud = 1'($urandom);
            ld = ($urandom_range(0, 9) == 0);
            lv = 4'($urandom);
            #1;
            if ($urandom_range(0, 29) == 0) begin
                clear = 1'b0; m_q = '{0, 0}; m_w = '{0, 0};
                #1;
                clear = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (dtc[k] !== model_tc(k)) begin
                    n_fail++; $display("FAIL rand_tc[%0d] it %0d: tc=%b expected %b",
                                       k, i, dtc[k], model_tc(k));
                end
            end
            step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (dq[k] !== 4'(m_q[k]) || dqb[k] !== ~4'(m_q[k]) || dw[k] !== m_w[k][0]) begin
                    n_fail++;
                    $display("FAIL rand_state[%0d] it %0d: Q=%h Qbar=%h w=%b expected Q=%h w=%b",
                             k, i, dq[k], dqb[k], dw[k], m_q[k], m_w[k][0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_down();
        test_saturate();
        test_load_clamp();
        test_async_clear();
        test_toggle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
